// File: rtl/fp_div_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fp_div_seq                                                 |
// | Description : Sequential binary64 divider, q = a * (rsqrt(|b|))^2.       |
// |               An external inverse-square-root estimator is driven via    |
// |               rsq_x and sampled via rsq_y. One shared truncating         |
// |               multiplier runs a fixed EST/SQ/MUL schedule. IEEE special  |
// |               cases are resolved at operand capture.                     |
// | Ports       : clk, rst_n         clock, async active-low reset           |
// |               in_valid/in_ready  operand handshake (a, b)                |
// |               rsq_x / rsq_y      estimator operand / estimate            |
// |               out_valid/out_ready quotient handshake (q)                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fp_div_seq #(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  output logic [BUS_WIDTH-1:0] rsq_x,
  input  logic [BUS_WIDTH-1:0] rsq_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] q
);

  localparam logic [63:0] C_QNAN    = 64'h7FF8_0000_0000_0000;
  localparam logic [62:0] C_INF_MAG = {11'h7FF, 52'h0};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EST  = 3'd1,
    S_SQ   = 3'd2,
    S_MUL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Operands are kept as magnitudes; the quotient sign is tracked separately.
  logic [62:0] r_a_mag;
  logic [62:0] r_b_mag;
  logic [62:0] r_y_mag;
  logic [62:0] r_t_mag;
  logic        r_sign;
  logic        r_special;
  logic [63:0] r_special_val;
  logic [63:0] r_q;

  // ---------------------------------------------------------------------
  // Operand classification (subnormals count as zero)
  // ---------------------------------------------------------------------
  logic        w_a_zero, w_a_inf, w_a_nan;
  logic        w_b_zero, w_b_inf, w_b_nan;
  logic        w_in_sign;
  logic        w_special;
  logic [63:0] w_special_val;

  always_comb begin
    w_a_zero  = (a[62:52] == 11'h000);
    w_a_inf   = (a[62:52] == 11'h7FF) && (a[51:0] == 52'h0);
    w_a_nan   = (a[62:52] == 11'h7FF) && (a[51:0] != 52'h0);
    w_b_zero  = (b[62:52] == 11'h000);
    w_b_inf   = (b[62:52] == 11'h7FF) && (b[51:0] == 52'h0);
    w_b_nan   = (b[62:52] == 11'h7FF) && (b[51:0] != 52'h0);
    w_in_sign = a[63] ^ b[63];

    w_special     = 1'b1;
    w_special_val = C_QNAN;
    if (w_a_nan || w_b_nan) begin
      w_special_val = C_QNAN;
    end else if (w_a_zero && w_b_zero) begin
      w_special_val = C_QNAN;
    end else if (w_a_inf && w_b_inf) begin
      w_special_val = C_QNAN;
    end else if (w_b_zero || w_a_inf) begin
      w_special_val = {w_in_sign, C_INF_MAG};
    end else if (w_b_inf || w_a_zero) begin
      w_special_val = {w_in_sign, 63'h0};
    end else begin
      w_special     = 1'b0;
      w_special_val = 64'h0;
    end
  end

  // ---------------------------------------------------------------------
  // Shared magnitude multiplier: SQ squares y, MUL scales |a| by t.
  // Both factors are non-negative, so no sign logic is needed here.
  // ---------------------------------------------------------------------
  logic [62:0]  w_mul_x;
  logic [62:0]  w_mul_y;
  logic [62:0]  w_mul_p;
  logic [105:0] w_prod;
  logic         w_norm;
  logic [51:0]  w_frac;
  logic [12:0]  w_exp_sum;

  always_comb begin
    w_mul_x = r_y_mag;
    w_mul_y = r_y_mag;
    if (r_state == S_MUL) begin
      w_mul_x = r_a_mag;
      w_mul_y = r_t_mag;
    end
  end

  always_comb begin
    w_prod    = {53'h0, 1'b1, w_mul_x[51:0]} * {53'h0, 1'b1, w_mul_y[51:0]};
    w_norm    = w_prod[105];
    w_frac    = w_norm ? w_prod[104:53] : w_prod[103:52];
    // Sum kept biased by 1023 so no signed arithmetic is required:
    // result exponent = w_exp_sum - 1023.
    w_exp_sum = {2'b00, w_mul_x[62:52]} + {2'b00, w_mul_y[62:52]} + {12'h000, w_norm};
    if ((w_mul_x[62:52] == 11'h000) || (w_mul_y[62:52] == 11'h000)) begin
      w_mul_p = 63'h0;
    end else if (w_exp_sum >= 13'd3070) begin
      w_mul_p = C_INF_MAG;
    end else if (w_exp_sum <= 13'd1023) begin
      w_mul_p = 63'h0;
    end else begin
      // In range 1..2046, so the low 11 bits give the exact difference.
      w_mul_p = {w_exp_sum[10:0] - 11'd1023, w_frac};
    end
  end

  // Truncation discards the low product bits; the estimate sign is irrelevant
  // because y is only ever squared.
  logic w_unused;
  assign w_unused = ^{w_prod[51:0], rsq_y[63]};

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_EST;
      S_EST:   w_state_nxt = S_SQ;
      S_SQ:    w_state_nxt = S_MUL;
      S_MUL:   w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_mag       <= 63'h0;
      r_b_mag       <= 63'h0;
      r_y_mag       <= 63'h0;
      r_t_mag       <= 63'h0;
      r_sign        <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= 64'h0;
      r_q           <= 64'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_mag       <= a[62:0];
            r_b_mag       <= b[62:0];
            r_sign        <= w_in_sign;
            r_special     <= w_special;
            r_special_val <= w_special_val;
          end
        end
        S_EST:   r_y_mag <= rsq_y[62:0];
        S_SQ:    r_t_mag <= w_mul_p;
        S_MUL:   r_q     <= r_special ? r_special_val : {r_sign, w_mul_p};
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign q         = r_q;
  // Derived from the captured divisor, so it moves only on accept edges.
  assign rsq_x     = {1'b0, r_b_mag};

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fp_div_seq                                              |
// | Description : Directed self-checking bench for fp_div_seq. The bench     |
// |               plays the estimator, supplying exact rsq_y values.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_fp_div_seq;

  localparam logic [63:0] C_ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] C_HALF  = 64'h3FE0_0000_0000_0000;
  localparam logic [63:0] C_TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] C_FOUR  = 64'h4010_0000_0000_0000;
  localparam logic [63:0] C_EIGHT = 64'h4020_0000_0000_0000;
  localparam logic [63:0] C_JUNK  = 64'h3FF8_1234_5678_9ABC;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] rsq_x;
  logic [63:0] rsq_y;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] q;

  int checks;
  int errors;

  fp_div_seq #(.BUS_WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .rsq_x     (rsq_x),
    .rsq_y     (rsq_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle. Returns #1 after the
  // edge that releases DONE, so a following call accepts back-to-back.
  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                        input logic [63:0] ty, input logic [63:0] exp_q, input int stall);
    check({tag, "_in_ready"}, {63'h0, in_ready}, 64'd1);
    a         = ta;
    b         = tb;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);                              // accept edge k
    #1;
    in_valid = 1'b0;
    a        = C_JUNK;
    b        = C_JUNK;
    rsq_y    = ty;
    check({tag, "_rsq_x"}, rsq_x, {1'b0, tb[62:0]});
    check({tag, "_busy"}, {63'h0, in_ready}, 64'd0);
    @(posedge clk);                              // k+1: estimate sampled
    #1;
    rsq_y = C_JUNK;
    check({tag, "_ov_k1"}, {63'h0, out_valid}, 64'd0);
    @(posedge clk);                              // k+2
    #1;
    check({tag, "_ov_k2"}, {63'h0, out_valid}, 64'd0);
    @(posedge clk);                              // k+3: result registered
    #1;
    check({tag, "_ov_k3"}, {63'h0, out_valid}, 64'd1);
    check({tag, "_q"}, q, exp_q);
    for (int i = 0; i < stall; i++) begin
      in_valid = (i % 2 == 0);
      a        = C_ONE;
      b        = C_EIGHT;
      @(posedge clk);
      #1;
      check({tag, "_stall_q"}, q, exp_q);
      check({tag, "_stall_ov"}, {63'h0, out_valid}, 64'd1);
      check({tag, "_stall_ir"}, {63'h0, in_ready}, 64'd0);
      check({tag, "_stall_x"}, rsq_x, {1'b0, tb[62:0]});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);                              // DONE released
    #1;
    out_ready = 1'b0;
    check({tag, "_ov_rel"}, {63'h0, out_valid}, 64'd0);
    check({tag, "_ir_rel"}, {63'h0, in_ready}, 64'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 64'h0;
    b         = 64'h0;
    rsq_y     = C_JUNK;

    #2;
    check("rst_in_ready", {63'h0, in_ready}, 64'd1);
    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_q", q, 64'h0);
    check("rst_rsq_x", rsq_x, 64'h0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Exact estimate and sign handling
    run_op("exact", C_EIGHT, C_FOUR, C_HALF, C_TWO, 0);
    run_op("neg_a", 64'hC020_0000_0000_0000, C_FOUR, C_HALF, 64'hC000_0000_0000_0000, 0);
    run_op("neg_b", C_EIGHT, 64'hC010_0000_0000_0000, C_HALF, 64'hC000_0000_0000_0000, 0);

    // Specials: estimate content is irrelevant
    run_op("one_div_zero", C_ONE, 64'h0, C_JUNK, 64'h7FF0_0000_0000_0000, 0);
    run_op("mone_div_zero", 64'hBFF0_0000_0000_0000, 64'h0, C_JUNK, 64'hFFF0_0000_0000_0000, 0);
    run_op("zero_div_zero", 64'h0, 64'h0, C_JUNK, 64'h7FF8_0000_0000_0000, 0);
    run_op("five_div_inf", 64'h4014_0000_0000_0000, 64'h7FF0_0000_0000_0000, C_JUNK, 64'h0, 0);

    // Backpressure, then an immediate back-to-back operation
    run_op("bp", C_EIGHT, C_FOUR, C_HALF, C_TWO, 10);
    run_op("b2b", 64'hC020_0000_0000_0000, C_FOUR, C_HALF, 64'hC000_0000_0000_0000, 0);

    // Overflow: max-ish / 0.25 with y = 2.0 -> t = 4.0 -> exponent 2048
    run_op("ovf", 64'h7FE0_0000_0000_0000, 64'h3FD0_0000_0000_0000, C_TWO,
           64'h7FF0_0000_0000_0000, 0);
    // Underflow: smallest normal / 4.0 -> exponent -1 flushes to zero
    run_op("unf", 64'h0010_0000_0000_0000, C_FOUR, C_HALF, 64'h0, 0);

    // Leave a nonzero q so the reset clear is observable
    run_op("pre_rst", C_EIGHT, C_FOUR, C_HALF, C_TWO, 0);

    // Reset during SQ
    a        = C_EIGHT;
    b        = C_FOUR;
    in_valid = 1'b1;
    @(posedge clk);                              // accept
    #1;
    in_valid = 1'b0;
    rsq_y    = C_HALF;
    @(posedge clk);                              // now in SQ
    #1;
    rsq_y = C_JUNK;
    check("mid_busy", {63'h0, in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ov", {63'h0, out_valid}, 64'd0);
    check("mid_rst_q", q, 64'h0);
    check("mid_rst_ir", {63'h0, in_ready}, 64'd1);
    check("mid_rst_x", rsq_x, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_out", {63'h0, out_valid}, 64'd0);
    end
    run_op("post_rst", C_EIGHT, C_FOUR, C_HALF, C_TWO, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
